inv_key_schedule: RTL
=====================

// Module: inv_key_schedule
// PURPOSE
//   Sequential AES-128 decryption key schedule. Takes the cipher key, runs the forward
//   expansion one round per cycle to reach the round-10 key, then streams the round keys
//   in reverse order (10 down to 0) over a valid/ready interface.
//   Feeds the inverse-cipher datapath, one round key per decryption round; reuses sbox.
// PARAMETERS
//   KEY_W  128  key and round-key width; only 128 is supported
//   NR     10   number of rounds; only 10 is supported; sets the rcon table length (rcon[1..10])
// PORTS
//   clk       in   1    single clock; all state updates on the rising edge
//   rst       in   1    asynchronous, active-high reset
//   start     in   1    load request; key_in is sampled when start && !busy
//   key_in    in   128  cipher key; bits [127:96] are word w0
//   busy      out  1    high from the accepting edge until the round-0 key is accepted
//   rk_valid  out  1    rk_data/rk_round hold a valid round key
//   rk_ready  in   1    consumer accepts the key on an edge where rk_valid && rk_ready
//   rk_round  out  4    round index of rk_data (10..0)
//   rk_data   out  128  round key
//   done      out  1    one-cycle pulse after the round-0 key is accepted
// BEHAVIOUR
//   Reset: all outputs 0; state=IDLE; key register 0. Reset is asynchronous and may be asserted
//     in any state; it aborts the schedule with no residual output.
//   FSM states: IDLE -> FWD -> REV -> IDLE. done is registered.
//   IDLE:
//     - start=1: load key_in into the key register, set cnt=1, busy=1, go to FWD.
//   FWD: each cycle, with w0..w3 the current key and g(w3)=SubWord(RotWord(w3))^rcon[cnt]:
//     - w0'=w0^g(w3), w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
//     - cnt increments; after the cnt=10 step, go to REV with rnd=10.
//   REV:
//     - rk_valid=1, rk_data=key register, rk_round=rnd.
//     - Outputs are held stable while rk_valid && !rk_ready.
//     - On accept with rnd>0, apply the inverse step with rcon[rnd]:
//       w3p=w3^w2, w2p=w2^w1, w1p=w1^w0, w0p=w0^g'(w3p), where g' uses w3p and rcon[rnd].
//       Then rnd decrements.
//     - On accept with rnd=0: rk_valid=0, busy=0, done=1 for one cycle, go to IDLE.
//   Latency and throughput:
//     - First rk_valid is high 11 cycles after the accepting edge (10 FWD cycles + 1).
//     - With rk_ready held high, one key per cycle; 22 cycles from start to done.
//   Boundary conditions:
//     - start while busy is ignored; key_in is not sampled.
//     - start in the same cycle as the done pulse is accepted; busy stays low only for that cycle.
//     - rk_ready is ignored while rk_valid=0.
//     - rcon: 01,02,04,08,10,20,40,80,1b,36 in byte 3; 0 for any other index.
// CONFIGURATION
//   EQ_INV_CIPHER_EN
//     - Defined: for rk_round 9..1, rk_data = InvMixColumns applied to each 32-bit column of
//       the round key (equivalent inverse cipher form).
//     - Defined: rounds 10 and 0 are output unmodified; the stored key register is never
//       transformed.
//     - Defined: added in the output path; latency is unchanged.
//     - Undefined: every round key is output raw; no InvMixColumns logic is built.
// TESTING
//   1. Reset, then start with key=2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1:
//      - first rk_data=d014f9a8c9ee2589e13f0cc8b6630ca6, round 10, 11 cycles after start;
//      - next rk_data=ac7766f319fadc2128d12941575c006e, round 9.
//   2. Same run:
//      - rk_round=4 gives 3d80477d4716fe3e1e237e446d7a883b;
//      - rk_round=0 gives 2b7e151628aed2a6abf7158809cf4f3c, done the next cycle, busy=0.
//   3. Backpressure: hold rk_ready=0 for 5 cycles at round 7:
//      - rk_data stays ef44a541a8525b7fb671253bdb0bad00;
//      - rk_round stays 7; no round is skipped.
//   4. Pulse start with key=0 mid-REV:
//      - start is ignored; the stream completes with the original key.
//      - Then start key=0: round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
//   5. Assert rst at round 5:
//      - all outputs 0 asynchronously;
//      - a new start gives round 10 again after 11 cycles.
//   6. With EQ_INV_CIPHER_EN: rounds 10 and 0 match scenario 1; rounds 9..1 equal the
//      column-wise InvMixColumns of the raw keys (bench C reference model).

Source files
------------

// File: rtl/inv_key_schedule.sv
// AES-128 decryption key schedule: forward-expands the cipher key to round 10, then streams keys 10..0.
// Optional EQ_INV_CIPHER_EN applies InvMixColumns to output rounds 9..1 (equivalent inverse cipher).
module inv_key_schedule #(
    parameter int KEY_W = 128,
    parameter int NR    = 10
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [KEY_W-1:0] i_key_in,
    output logic             o_busy,
    output logic             o_rk_valid,
    input  logic             i_rk_ready,
    output logic [3:0]       o_rk_round,
    output logic [KEY_W-1:0] o_rk_data,
    output logic             o_done
);
    // state | meaning
    // IDLE  | waiting for start
    // FWD   | forward expansion, one round per cycle, r_cnt = round being produced
    // REV   | presenting round key r_cnt, stepping backwards on each accept
    typedef enum logic [1:0] {S_IDLE, S_FWD, S_REV} state_t;

    localparam logic [3:0] LAST = 4'(NR);

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] g_fn(input logic [31:0] w, input logic [3:0] idx);
        return {sbox(w[23:16]) ^ rcon(idx), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [127:0] fwd_step(input logic [127:0] k, input logic [3:0] idx);
        logic [31:0] n0, n1, n2, n3;
        n0 = k[127:96] ^ g_fn(k[31:0], idx);
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [127:0] inv_step(input logic [127:0] k, input logic [3:0] idx);
        logic [31:0] p0, p1, p2, p3;
        p3 = k[31:0] ^ k[63:32];
        p2 = k[63:32] ^ k[95:64];
        p1 = k[95:64] ^ k[127:96];
        p0 = k[127:96] ^ g_fn(p3, idx);
        return {p0, p1, p2, p3};
    endfunction

`ifdef EQ_INV_CIPHER_EN
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
        logic [7:0] a [4];
        logic [7:0] m9 [4], m11 [4], m13 [4], m14 [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]   = w[31-8*i -: 8];
            x2     = xt(a[i]);
            x4     = xt(x2);
            x8     = xt(x4);
            m9[i]  = x8 ^ a[i];
            m11[i] = x8 ^ x2 ^ a[i];
            m13[i] = x8 ^ x4 ^ a[i];
            m14[i] = x8 ^ x4 ^ x2;
        end
        return {m14[0] ^ m11[1] ^ m13[2] ^ m9[3],
                m9[0]  ^ m14[1] ^ m11[2] ^ m13[3],
                m13[0] ^ m9[1]  ^ m14[2] ^ m11[3],
                m11[0] ^ m13[1] ^ m9[2]  ^ m14[3]};
    endfunction
`endif

    state_t             r_state;
    state_t             w_next;
    logic [KEY_W-1:0]   r_key;
    logic [3:0]         r_cnt;
    logic               r_done;
    logic [KEY_W-1:0]   w_fwd;
    logic [KEY_W-1:0]   w_inv;
    logic [KEY_W-1:0]   w_out;
    logic               w_accept;

    assign w_fwd    = fwd_step(r_key, r_cnt);
    assign w_inv    = inv_step(r_key, r_cnt);
    assign w_accept = (r_state == S_REV) && i_rk_ready;

`ifdef EQ_INV_CIPHER_EN
    // The stored key stays raw so the backward step keeps working; only the view is transformed.
    assign w_out = (r_cnt != 4'd0 && r_cnt != LAST)
                 ? {inv_mix_col(r_key[127:96]), inv_mix_col(r_key[95:64]),
                    inv_mix_col(r_key[63:32]), inv_mix_col(r_key[31:0])}
                 : r_key;
`else
    assign w_out = r_key;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_next = S_FWD;
            S_FWD:   if (r_cnt == LAST) w_next = S_REV;
            S_REV:   if (i_rk_ready && r_cnt == 4'd0) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy     = (r_state != S_IDLE);
        o_rk_valid = (r_state == S_REV);
        o_rk_round = (r_state == S_REV) ? r_cnt : 4'd0;
        o_rk_data  = (r_state == S_REV) ? w_out : '0;
        o_done     = r_done;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_key  <= '0;
            r_cnt  <= 4'd0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_accept && (r_cnt == 4'd0);
            case (r_state)
                S_IDLE: if (i_start) begin
                    r_key <= i_key_in;
                    r_cnt <= 4'd1;
                end
                S_FWD: begin
                    r_key <= w_fwd;
                    if (r_cnt != LAST) r_cnt <= r_cnt + 4'd1;
                end
                S_REV: if (i_rk_ready && r_cnt != 4'd0) begin
                    r_key <= w_inv;
                    r_cnt <= r_cnt - 4'd1;
                end
                default: ;
            endcase
        end
    end
endmodule
